// File: rtl/input_conditioner.sv
// Synchronises and debounces left/right/shoot buttons; levels flip DEBOUNCE_CYCLES+2 edges after raw input.
// Emits a one-cycle shoot pulse on press and left/right step pulses with press-and-hold auto-repeat.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic i_clk_25MHz,
  input  logic i_reset,
  input  logic i_left,
  input  logic i_right,
  input  logic i_shoot,
  output logic o_left,
  output logic o_right,
  output logic o_shoot_held,
  output logic o_left_step,
  output logic o_right_step,
  output logic o_shoot_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;

  // Bit order everywhere: [0] left, [1] right, [2] shoot.
  logic [2:0]    raw;
  logic [2:0]    s1_q, s1_d, s2_q, s2_d, level_q, level_d;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic          shoot_prev_q, shoot_prev_d, shoot_pulse_q, shoot_pulse_d;

  state_t        state_q, state_d;
  logic          dir_right_q, dir_right_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          left_step_q, left_step_d, right_step_q, right_step_d;
  logic          one_held, active_held;

  assign raw = {i_shoot, i_right, i_left};

  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    level_d = level_q;
    for (int b = 0; b < 3; b++) begin
      cnt_d[b] = '0;
      if (s2_q[b] != level_q[b]) begin
        if (cnt_q[b] == DB_LAST) level_d[b] = s2_q[b];
        else                     cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
    shoot_prev_d  = level_q[2];
    shoot_pulse_d = level_q[2] & ~shoot_prev_q;
  end

  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      s1_q          <= '0;
      s2_q          <= '0;
      level_q       <= '0;
      cnt_q         <= '{default: '0};
      shoot_prev_q  <= 1'b0;
      shoot_pulse_q <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      shoot_prev_q  <= shoot_prev_d;
      shoot_pulse_q <= shoot_pulse_d;
    end
  end

  // Both directions held counts as no direction, so the FSM idles until one is released.
  assign one_held    = level_q[0] ^ level_q[1];
  assign active_held = dir_right_q ? level_q[1] : level_q[0];

  always_comb begin
    state_d      = state_q;
    dir_right_d  = dir_right_q;
    rcnt_d       = rcnt_q;
    left_step_d  = 1'b0;
    right_step_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_held) begin
          dir_right_d  = level_q[1];
          left_step_d  = level_q[0];
          right_step_d = level_q[1];
          rcnt_d       = '0;
          state_d      = FIRST;
        end
      end
      FIRST, REPEAT: begin
        if (!active_held || !one_held) begin
          rcnt_d  = '0;
          state_d = IDLE;
        end else if (rcnt_q == ((state_q == FIRST) ? DELAY_LAST : PERIOD_LAST)) begin
          left_step_d  = ~dir_right_q;
          right_step_d = dir_right_q;
          rcnt_d       = '0;
          state_d      = REPEAT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      state_q      <= IDLE;
      dir_right_q  <= 1'b0;
      rcnt_q       <= '0;
      left_step_q  <= 1'b0;
      right_step_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_right_q  <= dir_right_d;
      rcnt_q       <= rcnt_d;
      left_step_q  <= left_step_d;
      right_step_q <= right_step_d;
    end
  end

  assign o_left        = level_q[0];
  assign o_right       = level_q[1];
  assign o_shoot_held  = level_q[2];
  assign o_left_step   = left_step_q;
  assign o_right_step  = right_step_q;
  assign o_shoot_pulse = shoot_pulse_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed vector table plus randomized button traffic against a reference model.
module tb_input_conditioner;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst, l, r, s;
  logic o_left, o_right, o_shoot_held, o_left_step, o_right_step, o_shoot_pulse;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .i_clk_25MHz  (clk),
    .i_reset      (rst),
    .i_left       (l),
    .i_right      (r),
    .i_shoot      (s),
    .o_left       (o_left),
    .o_right      (o_right),
    .o_shoot_held (o_shoot_held),
    .o_left_step  (o_left_step),
    .o_right_step (o_right_step),
    .o_shoot_pulse(o_shoot_pulse)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a level flips once the last DC synchronised samples all disagree with it;
  // steps are a function of how long one direction has been continuously the only one held.
  logic [2:0]  m_p1, m_p2, m_lvl;
  logic [31:0] m_hist [3];
  logic        m_prev, m_lstep, m_rstep, m_pulse;
  int          m_dir, m_age;
  localparam logic [31:0] MASK = (32'd1 << DC) - 32'd1;

  task automatic model_edge();
    logic pl, pr;
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_lvl = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
      m_prev = 0; m_lstep = 0; m_rstep = 0; m_pulse = 0;
      m_dir = 0; m_age = 0;
    end else begin
      pl = m_lvl[0];
      pr = m_lvl[1];
      m_pulse = m_lvl[2] & ~m_prev;
      m_prev  = m_lvl[2];
      m_lstep = 0;
      m_rstep = 0;
      if (m_dir == 0) begin
        if (pl ^ pr) begin
          m_dir = pl ? 1 : 2;
          m_age = 0;
          m_lstep = pl;
          m_rstep = pr;
        end
      end else if ((m_dir == 1 && !pl) || (m_dir == 2 && !pr) || (pl && pr)) begin
        m_dir = 0;
      end else begin
        m_age++;
        if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) begin
          m_lstep = (m_dir == 1);
          m_rstep = (m_dir == 2);
        end
      end
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = (m_hist[b] << 1) | {31'd0, m_p2[b]};
        if ((m_hist[b] & MASK) == (m_lvl[b] ? 32'd0 : MASK)) m_lvl[b] = m_p2[b];
      end
      m_p2 = m_p1;
      m_p1 = {s, r, l};
    end
  endtask

  function automatic logic [5:0] dut_out();
    return {o_left, o_right, o_shoot_held, o_left_step, o_right_step, o_shoot_pulse};
  endfunction

  task automatic check(string name, logic [5:0] got, logic [5:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, got, exp);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag, dut_out(), {m_lvl[0], m_lvl[1], m_lvl[2], m_lstep, m_rstep, m_pulse});
  endtask

  typedef struct {
    logic       rst, l, r, s;
    int         n;
    logic [5:0] exp;  // {left, right, shoot_held, left_step, right_step, shoot_pulse} after n edges
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic vr, logic vl, logic vrt, logic vs, int n, logic [5:0] exp);
    vec_t v;
    v.rst = vr; v.l = vl; v.r = vrt; v.s = vs; v.n = n; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    rst = 1; l = 1; r = 1; s = 1;

    // Reset with everything pressed, then release and watch levels settle.
    add(1, 1, 1, 1, 3, 6'b000000);
    add(0, 1, 1, 1, 5, 6'b000000);
    add(0, 1, 1, 1, 1, 6'b111000);
    add(0, 1, 1, 1, 1, 6'b111001);
    add(0, 1, 1, 1, 1, 6'b111000);
    add(0, 0, 0, 0, 5, 6'b111000);
    add(0, 0, 0, 0, 1, 6'b000000);
    // Left held: first step, delay, then period repeats.
    add(0, 1, 0, 0, 6, 6'b100000);
    add(0, 1, 0, 0, 1, 6'b100100);
    add(0, 1, 0, 0, 9, 6'b100000);
    add(0, 1, 0, 0, 1, 6'b100100);
    add(0, 1, 0, 0, 4, 6'b100000);
    add(0, 1, 0, 0, 1, 6'b100100);
    // Right joins: conflict silences steps; left released hands over to right.
    add(0, 1, 1, 0, 6, 6'b110000);
    add(0, 1, 1, 0, 1, 6'b110000);
    add(0, 1, 1, 0, 3, 6'b110000);
    add(0, 0, 1, 0, 5, 6'b110000);
    add(0, 0, 1, 0, 1, 6'b010000);
    add(0, 0, 1, 0, 1, 6'b010010);
    add(0, 0, 1, 0, 9, 6'b010000);
    add(0, 0, 1, 0, 1, 6'b010010);
    add(0, 0, 1, 0, 4, 6'b010000);
    add(0, 0, 1, 0, 1, 6'b010010);
    // One-cycle reset mid-repeat with right still held.
    add(1, 0, 1, 0, 1, 6'b000000);
    add(0, 0, 1, 0, 5, 6'b000000);
    add(0, 0, 1, 0, 1, 6'b010000);
    add(0, 0, 1, 0, 1, 6'b010010);
    add(0, 0, 0, 0, 6, 6'b000000);
    add(0, 0, 0, 0, 2, 6'b000000);
    // Raw pulse one sample short of the debounce threshold.
    add(0, 0, 1, 0, 3, 6'b000000);
    add(0, 0, 0, 0, 8, 6'b000000);
    // Bouncing shoot, then a clean hold.
    add(0, 0, 0, 1, 1, 6'b000000);
    add(0, 0, 0, 0, 1, 6'b000000);
    add(0, 0, 0, 1, 1, 6'b000000);
    add(0, 0, 0, 0, 1, 6'b000000);
    add(0, 0, 0, 1, 5, 6'b000000);
    add(0, 0, 0, 1, 1, 6'b001000);
    add(0, 0, 0, 1, 1, 6'b001001);
    add(0, 0, 0, 1, 10, 6'b001000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; l = vecs[i].l; r = vecs[i].r; s = vecs[i].s;
      for (int k = 0; k < vecs[i].n; k++) tick($sformatf("model row%0d", i));
      check($sformatf("row%0d", i), dut_out(), vecs[i].exp);
    end

    // Randomized traffic: mostly long holds, some sub-threshold glitches, occasional reset.
    for (int seg = 0; seg < 250; seg++) begin
      int hold;
      rst = ($urandom_range(0, 24) == 0);
      l = $urandom_range(0, 1);
      r = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      if (rst) hold = $urandom_range(1, 2);
      else if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, DC);
      else hold = $urandom_range(DC + 2, 3 * RD);
      for (int k = 0; k < hold; k++) tick($sformatf("random seg%0d", seg));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
